spw_ulight_pio_out: RTL and testbench

Parametrised Avalon-MM output PIO for the SpaceWire uLight FPGA systems. It drives board LEDs and static control lines from the Nios II system. It extends the fixed 6-bit output port with configurable width, atomic set/clear registers, and a per-bit hardware blink mode driven by a programmable prescaler. It sits on the system interconnect as a zero-wait-state slave; `out_port` goes to top-level pins.

---
 rtl/spw_ulight_pio_pkg.sv | 17 +
 rtl/spw_ulight_pio_out_if.sv | 14 +
 rtl/spw_ulight_pio_blink_timer.sv | 39 +++
 rtl/spw_ulight_pio_out.sv | 86 ++++++++
 tb/tb_spw_ulight_pio_out.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/spw_ulight_pio_pkg.sv
// Shared constants for the uLight output PIO: register map and reset defaults.
// Pure declarations, no logic.
package spw_ulight_pio_pkg;

    localparam logic [2:0] PIO_ADDR_DATA   = 3'd0;
    localparam logic [2:0] PIO_ADDR_BLINK  = 3'd1;
    localparam logic [2:0] PIO_ADDR_PERIOD = 3'd2;
    localparam logic [2:0] PIO_ADDR_SET    = 3'd3;
    localparam logic [2:0] PIO_ADDR_CLEAR  = 3'd4;

    localparam int          PIO_WIDTH          = 6;
    localparam int          PIO_PERIOD_W       = 26;
    localparam logic [31:0] PIO_RESET_VALUE    = 32'd1;
    // 0.5 s half-period at 50 MHz
    localparam logic [31:0] PIO_DEFAULT_PERIOD = 32'd24_999_999;

endpackage

// File: rtl/spw_ulight_pio_out_if.sv
// Avalon-MM slave bus bundle for the output PIO; zero-wait-state, no backpressure.
// readdata is combinational from address.
interface spw_ulight_pio_out_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/spw_ulight_pio_blink_timer.sv
// Free-running blink half-period timer; phase toggles every period+1 clocks.
// restart zeroes count and phase on the same edge; phase_next is the value phase takes at that edge.
module spw_ulight_pio_blink_timer #(
    parameter int PERIOD_W = 26
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] period,
    output logic                phase,
    output logic                phase_next
);

    logic [PERIOD_W-1:0] count_q;
    logic [PERIOD_W-1:0] count_next;

    always_comb begin
        count_next = count_q + PERIOD_W'(1);
        phase_next = phase;
        if (restart) begin
            count_next = '0;
            phase_next = 1'b0;
        end else if (count_q == period) begin
            count_next = '0;
            phase_next = ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            phase   <= 1'b0;
        end else begin
            count_q <= count_next;
            phase   <= phase_next;
        end
    end

endmodule

// File: rtl/spw_ulight_pio_out.sv
// Output PIO with DATA/BLINK/PERIOD/SET/CLEAR registers; writes reach out_port at the sampling edge.
// Reads are combinational (latency 0); zero wait states, never backpressures.
module spw_ulight_pio_out
    import spw_ulight_pio_pkg::*;
#(
    parameter int          WIDTH          = PIO_WIDTH,
    parameter logic [31:0] RESET_VALUE    = PIO_RESET_VALUE,
    parameter int          PERIOD_W       = PIO_PERIOD_W,
    parameter logic [31:0] DEFAULT_PERIOD = PIO_DEFAULT_PERIOD
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spw_ulight_pio_out_if.slave   bus,
    output logic [WIDTH-1:0]      out_port
);

    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    data_next;
    logic [WIDTH-1:0]    blink_q;
    logic [WIDTH-1:0]    blink_next;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_next;
    logic                wr_en;
    logic                period_wr;
    logic                phase;
    logic                phase_next;
    logic                unused_bits;

    assign wr_en       = bus.chipselect && !bus.write_n;
    assign period_wr   = wr_en && (bus.address == PIO_ADDR_PERIOD);
    assign unused_bits = ^{bus.writedata, phase};

    always_comb begin
        data_next   = data_q;
        blink_next  = blink_q;
        period_next = period_q;
        if (wr_en) begin
            case (bus.address)
                PIO_ADDR_DATA:   data_next   = bus.writedata[WIDTH-1:0];
                PIO_ADDR_BLINK:  blink_next  = bus.writedata[WIDTH-1:0];
                PIO_ADDR_PERIOD: period_next = bus.writedata[PERIOD_W-1:0];
                PIO_ADDR_SET:    data_next   = data_q | bus.writedata[WIDTH-1:0];
                PIO_ADDR_CLEAR:  data_next   = data_q & ~bus.writedata[WIDTH-1:0];
                default:         ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE[WIDTH-1:0];
            blink_q  <= '0;
            period_q <= DEFAULT_PERIOD[PERIOD_W-1:0];
            out_port <= RESET_VALUE[WIDTH-1:0];
        end else begin
            data_q   <= data_next;
            blink_q  <= blink_next;
            period_q <= period_next;
            // Use next-state terms so a write shows on the pin at the edge that samples it
            out_port <= data_next ^ (blink_next & {WIDTH{phase_next}});
        end
    end

    // The timer compares against the current PERIOD; a PERIOD write restarts it instead
    spw_ulight_pio_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .restart    (period_wr),
        .period     (period_q),
        .phase      (phase),
        .phase_next (phase_next)
    );

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            PIO_ADDR_DATA:   bus.readdata[WIDTH-1:0]    = data_q;
            PIO_ADDR_BLINK:  bus.readdata[WIDTH-1:0]    = blink_q;
            PIO_ADDR_PERIOD: bus.readdata[PERIOD_W-1:0] = period_q;
            default:         ;
        endcase
    end

endmodule

// File: tb/tb_spw_ulight_pio_out.sv
// Scoreboard bench for spw_ulight_pio_out: stimulus queues expected pin/read values per cycle,
// a negedge monitor pops and compares them.
module tb_spw_ulight_pio_out;
    import spw_ulight_pio_pkg::*;

    typedef struct {
        int          cyc;
        bit          is_rd;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [5:0] out_port;
    int         cyc;
    int         checks;
    int         errors;
    exp_t       q[$];

    spw_ulight_pio_out_if bus ();

    spw_ulight_pio_out dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation due in this cycle is compared at the falling edge
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e   = q.pop_front();
            act = e.is_rd ? bus.readdata : {26'b0, out_port};
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d reached monitor late at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", e.name, cyc, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int c, input logic [31:0] v, input string n);
        q.push_back('{c, 1'b0, v, n});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] v, input string n);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        q.push_back('{cyc, 1'b1, v, n});
        tick();
        bus.chipselect = 1'b0;
    endtask

    initial begin
        int ce;
        int ce2;
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset values
        repeat (3) tick();
        exp_at(cyc, 32'h01, "rst_out");
        reset_n = 1'b1;
        rd(PIO_ADDR_DATA,   32'h1,        "rst_data");
        rd(PIO_ADDR_BLINK,  32'h0,        "rst_blink");
        rd(PIO_ADDR_PERIOD, 32'd24999999, "rst_period");

        // DATA / SET / CLEAR and reserved addresses
        wr(PIO_ADDR_DATA, 32'h3C);  exp_at(cyc, 32'h3C, "data_wr");
        wr(PIO_ADDR_SET, 32'h03);   exp_at(cyc, 32'h3F, "set");
        wr(PIO_ADDR_CLEAR, 32'h30); exp_at(cyc, 32'h0F, "clear");
        rd(PIO_ADDR_SET,   32'h0, "rd_set");
        rd(PIO_ADDR_CLEAR, 32'h0, "rd_clear");
        wr(3'd5, 32'hFF);           exp_at(cyc, 32'h0F, "rsvd_wr");
        rd(3'd5, 32'h0, "rd_rsvd");
        wr(PIO_ADDR_DATA, 32'hFFFF_FFFF); exp_at(cyc, 32'h3F, "data_ones");
        rd(PIO_ADDR_DATA, 32'h3F, "rd_data_ones");
        wr(PIO_ADDR_PERIOD, 32'hFFFF_FFFF);
        rd(PIO_ADDR_PERIOD, 32'h03FF_FFFF, "rd_period_trunc");

        // Blink with PERIOD=3: 4 clocks per half-period from the PERIOD write
        wr(PIO_ADDR_PERIOD, 32'd3);
        ce = cyc;
        wr(PIO_ADDR_DATA, 32'h0);
        for (int d = 1; d <= 12; d++) exp_at(ce + d, ((d / 4) % 2) != 0 ? 32'h05 : 32'h00, "blink3");
        wr(PIO_ADDR_BLINK, 32'h05);
        while (cyc < ce + 12) tick();
        wr(PIO_ADDR_BLINK, 32'h0);
        exp_at(cyc,     32'h00, "blink_off");
        exp_at(cyc + 1, 32'h00, "blink_off_hold");
        repeat (2) tick();

        // PERIOD=0: bit 0 toggles every clock, starting at 1
        wr(PIO_ADDR_DATA, 32'h1);
        wr(PIO_ADDR_BLINK, 32'h1);
        wr(PIO_ADDR_PERIOD, 32'd0);
        ce = cyc;
        for (int d = 0; d < 8; d++) exp_at(ce + d, (d % 2) == 0 ? 32'h01 : 32'h00, "period0");
        repeat (8) tick();

        // PERIOD rewrite while phase is 1
        wr(PIO_ADDR_DATA, 32'h0);
        wr(PIO_ADDR_BLINK, 32'h1);
        wr(PIO_ADDR_PERIOD, 32'd3);
        ce = cyc;
        for (int d = 0; d <= 5; d++) exp_at(ce + d, d >= 4 ? 32'h01 : 32'h00, "pre_rewrite");
        while (cyc < ce + 5) tick();
        wr(PIO_ADDR_PERIOD, 32'd5);
        ce2 = cyc;
        for (int d = 0; d <= 9; d++) exp_at(ce2 + d, d >= 6 ? 32'h01 : 32'h00, "rewrite5");
        while (cyc < ce2 + 9) tick();

        // Reset during phase 1 with a concurrent SET
        bus.address    = PIO_ADDR_SET;
        bus.writedata  = 32'h3E;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        reset_n        = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset_n        = 1'b1;
        exp_at(cyc, 32'h01, "midrst_out");
        rd(PIO_ADDR_DATA,   32'h1,        "midrst_data");
        exp_at(cyc, 32'h01, "midrst_out_hold");
        rd(PIO_ADDR_BLINK,  32'h0,        "midrst_blink");
        rd(PIO_ADDR_PERIOD, 32'd24999999, "midrst_period");

        for (int i = 0; i < 50 && q.size() > 0; i++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
